bcd_stopwatch_core: RTL and testbench

BCD_STOPWATCH_CORE -- requirements
Module: bcd_stopwatch_core

---
 rtl/bcd_stopwatch_pkg.sv | 25 ++
 rtl/bcd_stopwatch_core_digit_step.sv | 19 +
 rtl/bcd_stopwatch_core.sv | 147 ++++++++++++++
 tb/tb_bcd_stopwatch_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_pkg.sv
// bcd_stopwatch_pkg: shared state/speed encodings and BCD digit constants
package bcd_stopwatch_pkg;

    localparam int DIGIT_W   = 4;
    localparam int SIX_DIGIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SPD_SLOW = 2'd0,
        SPD_NORM = 2'd1,
        SPD_FAST = 2'd2
    } speed_t;

    // largest legal value of digit idx; the tens-of-seconds digit wraps at 6
    function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
        return (idx == SIX_DIGIT) ? DIGIT_W'(5) : DIGIT_W'(9);
    endfunction

endpackage

// File: rtl/bcd_stopwatch_core_digit_step.sv
// bcd_digit_step: one BCD digit incremented or decremented with radix wrap and ripple carry
module bcd_digit_step
    import bcd_stopwatch_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    input  logic [DIGIT_W-1:0] dmax,
    input  logic               down,
    input  logic               ci,
    output logic [DIGIT_W-1:0] q,
    output logic               co
);

    // wrap to 0 (up) or dmax (down) and pass the carry/borrow upward
    always_comb begin
        co = ci & (down ? (d == '0) : (d >= dmax));
        q  = !ci ? d : co ? (down ? dmax : '0) : (down ? d - DIGIT_W'(1) : d + DIGIT_W'(1));
    end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// bcd_stopwatch_core: up/down BCD stopwatch with prescaled ticks; STOPWATCH_LAP_EN adds lap capture
module bcd_stopwatch_core
    import bcd_stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TOP_MAX    = 1,
    parameter int DIV_SLOW   = 27,
    parameter int DIV_NORM   = 25,
    parameter int DIV_FAST   = 21
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          clear_i,
    input  logic                          lap_i,
    input  logic                          dir_i,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] preset_i,
    input  logic                          fast_i,
    input  logic                          slow_i,
    input  logic                          hold_mode_i,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_o,
    output logic [DIGIT_W*NUM_DIGITS-1:0] lap_o,
    output logic                          lap_valid_o,
    output logic [1:0]                    state_o,
    output logic [1:0]                    speed_o,
    output logic                          tick_o,
    output logic                          done_o
);

    localparam int W  = DIGIT_W * NUM_DIGITS;
    localparam int PW = (DIV_SLOW > DIV_NORM) ? ((DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST)
                                              : ((DIV_NORM > DIV_FAST) ? DIV_NORM : DIV_FAST);
    localparam logic [PW-1:0] M_SLOW = {PW{1'b1}} >> (PW - DIV_SLOW);
    localparam logic [PW-1:0] M_NORM = {PW{1'b1}} >> (PW - DIV_NORM);
    localparam logic [PW-1:0] M_FAST = {PW{1'b1}} >> (PW - DIV_FAST);
    localparam logic [W-1:0]  TERM   = W'(TOP_MAX) << (DIGIT_W * (NUM_DIGITS - 1));

    state_t              state, state_nx;
    speed_t              speed, speed_nx;
    logic [W-1:0]        cnt, cnt_nx, step_v, clamp_v;
    logic [NUM_DIGITS:0] c;
    logic [PW-1:0]       pre, mask;
    logic                down_q, fast_q, slow_q, tick, fast_rise, slow_rise, load;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        localparam logic [DIGIT_W-1:0] MX = digit_max(i);
        bcd_digit_step u_step (
            .d    (cnt[i*DIGIT_W +: DIGIT_W]),
            .dmax (MX),
            .down (down_q),
            .ci   (c[i]),
            .q    (step_v[i*DIGIT_W +: DIGIT_W]),
            .co   (c[i+1])
        );
        assign clamp_v[i*DIGIT_W +: DIGIT_W] = (preset_i[i*DIGIT_W +: DIGIT_W] > MX) ? MX : preset_i[i*DIGIT_W +: DIGIT_W];
    end

    assign mask      = (speed == SPD_FAST) ? M_FAST : (speed == SPD_SLOW) ? M_SLOW : M_NORM;
    assign tick      = &(pre | ~mask);
    assign load      = !clear_i && start_i && (state == ST_IDLE);
    assign fast_rise = fast_i && !fast_q;
    assign slow_rise = slow_i && !slow_q;

    // state and count: clear beats start beats tick; a borrow out of the top digit means the count was already zero
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (clear_i) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
        end else if (start_i) begin
            state_nx = (state == ST_IDLE || state == ST_PAUSE) ? ST_RUN : (state == ST_RUN) ? ST_PAUSE : ST_DONE;
            cnt_nx   = (state == ST_IDLE) ? (dir_i ? clamp_v : '0) : cnt;
        end else if (tick && state == ST_RUN) begin
            cnt_nx   = (down_q && c[NUM_DIGITS]) ? cnt : step_v;
            state_nx = (down_q ? (c[NUM_DIGITS] || step_v == '0) : (step_v == TERM)) ? ST_DONE : ST_RUN;
        end
    end

    // speed: momentary mode follows the levels, sticky mode reacts to a single rising request
    always_comb begin
        speed_nx = speed;
        if (clear_i)
            speed_nx = SPD_NORM;
        else if (hold_mode_i)
            speed_nx = fast_i ? SPD_FAST : slow_i ? SPD_SLOW : SPD_NORM;
        else if ((state == ST_RUN || state == ST_PAUSE) && (fast_rise != slow_rise))
            speed_nx = fast_rise ? SPD_FAST : SPD_SLOW;
    end

    // registered state, count, speed, free-running prescaler and request edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            speed  <= SPD_NORM;
            pre    <= '0;
            down_q <= 1'b0;
            fast_q <= 1'b0;
            slow_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            speed  <= speed_nx;
            pre    <= (clear_i || load) ? '0 : pre + PW'(1);
            down_q <= load ? dir_i : down_q;
            fast_q <= fast_i;
            slow_q <= slow_i;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [W-1:0] lap_q;
    logic         lap_v_q;

    // capture the displayed (pre-update) count on a lap request outside IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q   <= '0;
            lap_v_q <= 1'b0;
        end else if (clear_i) begin
            lap_q   <= '0;
            lap_v_q <= 1'b0;
        end else if (lap_i && !start_i && state != ST_IDLE) begin
            lap_q   <= cnt;
            lap_v_q <= 1'b1;
        end
    end

    assign lap_o       = lap_q;
    assign lap_valid_o = lap_v_q;
`else
    logic unused_lap;
    assign unused_lap  = lap_i;
    assign lap_o       = '0;
    assign lap_valid_o = 1'b0;
`endif

    assign bcd_o   = cnt;
    assign state_o = state;
    assign speed_o = speed;
    assign tick_o  = tick;
    assign done_o  = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// tb_bcd_stopwatch_core: scoreboard bench against an integer-time stopwatch model
module tb_bcd_stopwatch_core;

    localparam int TOP = 1;
    localparam int DS  = 4;
    localparam int DN  = 3;
    localparam int DF  = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_i = 1'b0, clear_i = 1'b0, lap_i = 1'b0, dir_i = 1'b0;
    logic        fast_i = 1'b0, slow_i = 1'b0, hold_mode_i = 1'b0;
    logic [15:0] preset_i = '0;
    logic [15:0] bcd_o, lap_o;
    logic [1:0]  state_o, speed_o;
    logic        lap_valid_o, tick_o, done_o;

    logic        nx_dir = 1'b0, nx_fast = 1'b0, nx_slow = 1'b0, nx_hold = 1'b0;
    logic [15:0] nx_preset = '0;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] bcd;
        logic [1:0]  spd;
        logic        tick;
        logic        done;
        logic [15:0] lap;
        logic        lv;
    } obs_t;

    obs_t exp_q[$];
    int   n_chk = 0, n_fail = 0;

    int m_st, m_n, m_spd, m_pre, m_lap;
    bit m_dir, m_lv, m_fq, m_sq;

    always #5 clk = ~clk;

    bcd_stopwatch_core #(
        .NUM_DIGITS (4),
        .TOP_MAX    (TOP),
        .DIV_SLOW   (DS),
        .DIV_NORM   (DN),
        .DIV_FAST   (DF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .lap_i       (lap_i),
        .dir_i       (dir_i),
        .preset_i    (preset_i),
        .fast_i      (fast_i),
        .slow_i      (slow_i),
        .hold_mode_i (hold_mode_i),
        .bcd_o       (bcd_o),
        .lap_o       (lap_o),
        .lap_valid_o (lap_valid_o),
        .state_o     (state_o),
        .speed_o     (speed_o),
        .tick_o      (tick_o),
        .done_o      (done_o)
    );

    // time in ticks -> display digits: seconds, tens of seconds (mod 6), minutes, tens of minutes
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 600 % 10), 4'(v / 60 % 10), 4'(v / 10 % 6), 4'(v % 10)};
    endfunction

    function automatic int from_preset(input logic [15:0] p);
        int lim[4] = '{9, 5, 9, 9};
        int w[4]   = '{1, 10, 60, 600};
        int s      = 0;
        for (int k = 0; k < 4; k++) begin
            int d = int'(p[k*4 +: 4]);
            s += ((d > lim[k]) ? lim[k] : d) * w[k];
        end
        return s;
    endfunction

    function automatic bit tick_of(input int pre, input int spd);
        int p = 1 << ((spd == 2) ? DF : (spd == 0) ? DS : DN);
        return (pre % p) == (p - 1);
    endfunction

    function automatic obs_t model_exp();
        obs_t e;
        e.st   = 2'(m_st);
        e.bcd  = to_bcd(m_n);
        e.spd  = 2'(m_spd);
        e.tick = tick_of(m_pre, m_spd);
        e.done = (m_st == 3);
        e.lap  = to_bcd(m_lap);
        e.lv   = m_lv;
        return e;
    endfunction

    task automatic model_reset();
        m_st = 0; m_n = 0; m_spd = 1; m_pre = 0; m_lap = 0;
        m_dir = 0; m_lv = 0; m_fq = 0; m_sq = 0;
    endtask

    task automatic chk(input string nm, input obs_t e);
        obs_t a;
        a = {state_o, bcd_o, speed_o, tick_o, done_o, lap_o, lap_valid_o};
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got st=%0d bcd=%h spd=%0d tick=%b done=%b lap=%h lv=%b, want st=%0d bcd=%h spd=%0d tick=%b done=%b lap=%h lv=%b",
                     nm, $time, a.st, a.bcd, a.spd, a.tick, a.done, a.lap, a.lv,
                     e.st, e.bcd, e.spd, e.tick, e.done, e.lap, e.lv);
        end
    endtask

    // drive one cycle of inputs, advance the model across the coming edge, queue the expected outputs
    task automatic step(input bit s = 1'b0, input bit c = 1'b0, input bit l = 1'b0);
        bit tk, rf, rs;
        @(negedge clk);
        rst_n = 1'b1; start_i = s; clear_i = c; lap_i = l;
        dir_i = nx_dir; preset_i = nx_preset; fast_i = nx_fast; slow_i = nx_slow; hold_mode_i = nx_hold;
        tk = tick_of(m_pre, m_spd) && (m_st == 1);
        rf = nx_fast && !m_fq;
        rs = nx_slow && !m_sq;
`ifdef STOPWATCH_LAP_EN
        if (c) begin m_lap = 0; m_lv = 0; end
        else if (l && !s && m_st != 0) begin m_lap = m_n; m_lv = 1; end
`endif
        if (c) m_spd = 1;
        else if (nx_hold) m_spd = nx_fast ? 2 : nx_slow ? 0 : 1;
        else if ((m_st == 1 || m_st == 2) && rf != rs) m_spd = rf ? 2 : 0;
        m_fq = nx_fast;
        m_sq = nx_slow;
        m_pre = (c || (s && m_st == 0)) ? 0 : m_pre + 1;
        if (c) begin
            m_st = 0; m_n = 0;
        end else if (s) begin
            if (m_st == 0) begin
                m_dir = nx_dir;
                m_n   = nx_dir ? from_preset(nx_preset) : 0;
                m_st  = 1;
            end else if (m_st == 1) m_st = 2;
            else if (m_st == 2) m_st = 1;
        end else if (tk) begin
            if (!m_dir) begin
                m_n++;
                if (m_n == TOP * 600) m_st = 3;
            end else begin
                if (m_n > 0) m_n--;
                if (m_n == 0) m_st = 3;
            end
        end
        exp_q.push_back(model_exp());
    endtask

    // monitor: every edge that has a queued expectation is checked just after the edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) chk("cycle", exp_q.pop_front());
    end

    initial begin
        int g;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset", model_exp());

        // up count through 0009, 0059, 0959 to terminal 1000, lap at 0023, start ignored in DONE
        step(1);
        g = 0;
        while (m_st != 3 && g < 7000) begin step(1'b0, 1'b0, m_n == 23); g++; end
        repeat (10) step();
        step(1);
        repeat (10) step();
        step(1, 1);
        repeat (5) step();

        // down count from 0100 with dir changed after start
        nx_dir = 1; nx_preset = 16'h0100;
        step(1);
        nx_dir = 0;
        g = 0;
        while (m_st != 3 && g < 1000) begin step(); g++; end
        repeat (20) step();
        step(0, 1);

        // zero preset and over-range preset clamping
        nx_dir = 1; nx_preset = 16'h0000;
        step(1);
        repeat (12) step();
        step(0, 1);
        nx_preset = 16'hFFFF;
        step(1);
        repeat (20) step();
        step(0, 1);
        nx_dir = 0;

        // sticky speed: fast pulse, slow pulse, simultaneous rise
        step(1);
        repeat (10) step();
        nx_fast = 1; step(); nx_fast = 0;
        repeat (20) step();
        nx_slow = 1; step(); nx_slow = 0;
        repeat (40) step();
        nx_fast = 1; nx_slow = 1; step(); nx_fast = 0; nx_slow = 0;
        repeat (20) step();
        step(0, 1);

        // momentary speed: slow held 40 cycles then released
        nx_hold = 1;
        step(1);
        repeat (10) step();
        nx_slow = 1;
        repeat (40) step();
        nx_slow = 0;
        repeat (30) step();
        nx_hold = 0;
        step(0, 1);

        // start colliding with a tick pauses without counting, second start resumes
        step(1);
        repeat (20) step();
        g = 0;
        while (!tick_of(m_pre, m_spd) && g < 40) begin step(); g++; end
        step(1);
        repeat (20) step();
        step(0, 0, 1);
        step(1);
        repeat (30) step();

        // asynchronous reset in the middle of the low clock phase while running
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1 chk("async_reset", model_exp());
        @(negedge clk);
        repeat (3) step();

        // randomized traffic
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 49) == 0) nx_hold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 14) == 0) nx_fast = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 14) == 0) nx_slow = 1'($urandom_range(0, 1));
            nx_dir    = 1'($urandom_range(0, 1));
            nx_preset = 16'($urandom);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0);
        end

        step();
        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
